// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch front end: PC, req/gnt/rvalid fetch, redirect flush, decode FIFO
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        jump_en_i,
   input  logic [31:0] jump_addr_i,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o
);

   localparam int          PW      = $clog2(DEPTH);
   localparam int          CW      = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
   localparam logic [PW-1:0] P_ONE = PW'(1);
   localparam logic [CW-1:0] C_ONE = CW'(1);

   logic [31:0]   r_pc;
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] r_drop_cnt;
   logic [CW-1:0] r_count;
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_ifq_rd;
   logic [PW-1:0] r_ifq_wr;
   logic [31:0]   r_fifo_addr [DEPTH];
   logic [31:0]   r_fifo_inst [DEPTH];
   logic [31:0]   r_ifq_addr  [DEPTH];

   logic [CW:0]   w_used;
   logic          w_grant;
   logic          w_drop;
   logic          w_push;
   logic          w_pop;
   logic [CW-1:0] w_grant_c;
   logic [CW-1:0] w_resp_c;
   logic [CW-1:0] w_push_c;
   logic [CW-1:0] w_pop_c;

   // Credit covers both in-flight and buffered words, so a granted word always has a slot.
   assign w_used       = {1'b0, r_outstanding} + {1'b0, r_count};
   assign mem_req_o    = rst & ~jump_en_i & (w_used < DEPTH_W);
   assign mem_addr_o   = r_pc;
   assign w_grant      = mem_req_o & mem_gnt_i;
   assign w_drop       = mem_rvalid_i & (r_drop_cnt != '0);
   assign w_push       = mem_rvalid_i & ~jump_en_i & (r_drop_cnt == '0);
   assign inst_valid_o = (r_count != '0) & ~jump_en_i;
   assign w_pop        = inst_valid_o & inst_ready_i;
   assign inst_o       = r_fifo_inst[r_rd_ptr];
   assign inst_addr_o  = r_fifo_addr[r_rd_ptr];

   assign w_grant_c = {{(CW-1){1'b0}}, w_grant};
   assign w_resp_c  = {{(CW-1){1'b0}}, mem_rvalid_i};
   assign w_push_c  = {{(CW-1){1'b0}}, w_push};
   assign w_pop_c   = {{(CW-1){1'b0}}, w_pop};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc          <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
         r_count       <= '0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
      end else begin
         r_outstanding <= r_outstanding + w_grant_c - w_resp_c;
         if (jump_en_i) begin
            r_pc       <= {jump_addr_i[31:2], 2'b00};
            // Every request still in flight after this cycle belongs to the old stream.
            r_drop_cnt <= r_outstanding - w_resp_c;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
         end else begin
            if (w_grant) r_pc <= r_pc + 32'd4;
            if (w_drop) r_drop_cnt <= r_drop_cnt - C_ONE;
            r_count <= r_count + w_push_c - w_pop_c;
            if (w_push) r_wr_ptr <= r_wr_ptr + P_ONE;
            if (w_pop) r_rd_ptr <= r_rd_ptr + P_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ifq_rd <= '0;
         r_ifq_wr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_ifq_addr[i]  <= '0;
            r_fifo_addr[i] <= '0;
            r_fifo_inst[i] <= '0;
         end
      end else begin
         if (w_grant) begin
            r_ifq_addr[r_ifq_wr] <= r_pc;
            r_ifq_wr             <= r_ifq_wr + P_ONE;
         end
         if (mem_rvalid_i) r_ifq_rd <= r_ifq_rd + P_ONE;
         if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= r_ifq_addr[r_ifq_rd];
            r_fifo_inst[r_wr_ptr] <= mem_rdata_i;
         end
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         assert (w_used <= DEPTH_W);
         assert (!(mem_rvalid_i && (r_outstanding == '0)));
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit with a queue-based stream model
module tb_if_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_gnt_i    = 1'b0;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i  = '0;
   logic        jump_en_i    = 1'b0;
   logic [31:0] jump_addr_i  = '0;
   logic        inst_valid_o;
   logic        inst_ready_i = 1'b0;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;

   always #5 clk = ~clk;

   if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .jump_en_i    (jump_en_i),
      .jump_addr_i  (jump_addr_i),
      .inst_valid_o (inst_valid_o),
      .inst_ready_i (inst_ready_i),
      .inst_o       (inst_o),
      .inst_addr_o  (inst_addr_o)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic        live;
   } infl_t;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [31:0] mq[$];
   infl_t       m_infl[$];
   logic [31:0] m_fifo[$];
   logic [31:0] m_pc;
   int          gnt_pct = 100;
   int          rv_pct  = 100;
   int          rdy_pct = 100;
   int          jmp_pct = 0;

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   function automatic logic pick(input int pct);
      return ($urandom_range(99) < pct);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      mem_gnt_i    = pick(gnt_pct);
      mem_rvalid_i = (mq.size() != 0) && pick(rv_pct);
      mem_rdata_i  = mem_rvalid_i ? mdata(mq[0]) : $urandom;
      inst_ready_i = pick(rdy_pct);
      jump_en_i    = pick(jmp_pct);
      jump_addr_i  = $urandom;
   endtask

   // Called at posedge+1 with inputs set; checks at mid-cycle, then advances the model past the edge.
   task automatic cycle();
      logic  exp_req;
      logic  exp_val;
      infl_t e;
      #3;
      exp_req = rst && !jump_en_i && (m_infl.size() + m_fifo.size() < DEPTH);
      exp_val = rst && !jump_en_i && (m_fifo.size() != 0);
      check("mem_req_o", 32'(mem_req_o), 32'(exp_req));
      check("inst_valid_o", 32'(inst_valid_o), 32'(exp_val));
      if (exp_req) check("mem_addr_o", mem_addr_o, m_pc);
      if (exp_val) begin
         check("inst_addr_o", inst_addr_o, m_fifo[0]);
         check("inst_o", inst_o, mdata(m_fifo[0]));
      end
      if (mem_rvalid_i) void'(mq.pop_front());
      if (mem_req_o && mem_gnt_i) mq.push_back(mem_addr_o);
      if (rst) begin
         if (exp_val && inst_ready_i) void'(m_fifo.pop_front());
         if (mem_rvalid_i && m_infl.size() != 0) begin
            e = m_infl.pop_front();
            if (e.live && !jump_en_i) m_fifo.push_back(e.addr);
         end
         if (jump_en_i) begin
            m_fifo.delete();
            foreach (m_infl[i]) m_infl[i].live = 1'b0;
            m_pc = {jump_addr_i[31:2], 2'b00};
         end else if (exp_req && mem_gnt_i) begin
            e.addr = m_pc;
            e.live = 1'b1;
            m_infl.push_back(e);
            m_pc = m_pc + 32'd4;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) begin
         drive();
         cycle();
      end
   endtask

   task automatic jump_to(input logic [31:0] target);
      drive();
      jump_en_i   = 1'b1;
      jump_addr_i = target;
      cycle();
   endtask

   initial begin
      m_pc = RESET_PC;
      @(posedge clk);
      #1;
      check("reset_req", 32'(mem_req_o), 32'd0);
      check("reset_valid", 32'(inst_valid_o), 32'd0);
      check("reset_inst", inst_o, 32'd0);
      check("reset_inst_addr", inst_addr_o, 32'd0);
      cycle();
      cycle();
      rst = 1'b1;

      // 1-cycle memory, decode always ready
      run(16);

      // decode stalled: buffer fills to DEPTH, requests stop
      rdy_pct = 0;
      run(10);
      check("stall_req_off", 32'(mem_req_o), 32'd0);
      check("stall_valid", 32'(inst_valid_o), 32'd1);
      rdy_pct = 100;
      run(8);

      // redirect with two requests in flight
      rv_pct = 0;
      run(4);
      check("inflight_before_jump", 32'(mq.size()), 32'd2);
      jump_to(32'h0000_0103);
      check("jump_pc", mem_addr_o, 32'h0000_0100);
      rv_pct = 100;
      run(10);

      // grant stall holds the request
      gnt_pct = 0;
      run(5);
      check("gnt_stall_req", 32'(mem_req_o), 32'd1);
      check("gnt_stall_addr", mem_addr_o, m_pc);
      gnt_pct = 100;
      run(6);

      // address wrap at the top of memory
      jump_to(32'hFFFF_FFF9);
      check("wrap_start", mem_addr_o, 32'hFFFF_FFF8);
      run(12);

      // randomized mix of stalls, latencies and redirects
      for (int blk = 0; blk < 6; blk++) begin
         gnt_pct = $urandom_range(100, 30);
         rv_pct  = $urandom_range(100, 30);
         rdy_pct = $urandom_range(100, 30);
         jmp_pct = $urandom_range(10, 2);
         run(80);
      end

      // reset mid-stream with the buffer full
      gnt_pct = 100; rv_pct = 100; rdy_pct = 0; jmp_pct = 0;
      run(8);
      check("full_before_reset", 32'(inst_valid_o), 32'd1);
      rst = 1'b0;
      #1;
      check("async_reset_req", 32'(mem_req_o), 32'd0);
      check("async_reset_valid", 32'(inst_valid_o), 32'd0);
      check("async_reset_inst", inst_o, 32'd0);
      check("async_reset_inst_addr", inst_addr_o, 32'd0);
      mq.delete();
      m_fifo.delete();
      m_infl.delete();
      m_pc         = RESET_PC;
      mem_rvalid_i = 1'b0;
      jump_en_i    = 1'b0;
      cycle();
      cycle();
      rst = 1'b1;
      check("restart_addr", mem_addr_o, RESET_PC);
      rdy_pct = 100;
      run(16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
